// File: rtl/lrsc_reservation_ctrl.sv
// -----------------------------------------------------------------------------
// lrsc_reservation_ctrl
//
// Owns the single-hart LR/SC reservation and arbitrates the shared data-memory
// write path against external masters (DMA/debug).
//   - LR retirement sets the reservation (address, loaded data, expiry timer).
//   - Conflicting snoop writes, matching local stores, traps and timer expiry
//     drop it.
//   - While an SC sequence is in flight, external writes are held off so the
//     compare-and-store seen by the lrsc sequencer stays atomic.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles a reservation lives after LR (0 = never expires)
//   GRANULE_LOG2    reservation granule is 2**GRANULE_LOG2 bytes
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   stall                   qualifies lr/sc_start/sc_done/local_store
//   lr_commit_i/addr/data   LR.W retirement with its address and loaded value
//   sc_start_i, sc_done_i   SC sequence begins / final STORE cycle
//   sc_result_i             SC result (0 = success), valid with sc_done_i
//   local_store_i/addr      ordinary store from this hart commits
//   trap_i                  exception/interrupt/xRET taken
//   snoop_valid_i/addr_i    external master write request
//   snoop_ready_o           external write may proceed (combinational)
//   reservation_addr_o      reserved address, 32'h1 when no reservation
//   reservation_data_o      value loaded by the last reserving LR
//   reservation_valid_o     reservation held
//
// Optional feature (define LRSC_STATS_EN):
//   sc_success_cnt_o, sc_fail_cnt_o, snoop_stall_cnt_o saturating counters.
// -----------------------------------------------------------------------------
module lrsc_reservation_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned GRANULE_LOG2   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        lr_commit_i,
  input  logic [31:0] lr_addr_i,
  input  logic [31:0] lr_data_i,
  input  logic        sc_start_i,
  input  logic        sc_done_i,
  input  logic        sc_result_i,
  input  logic        local_store_i,
  input  logic [31:0] local_store_addr_i,
  input  logic        trap_i,
  input  logic        snoop_valid_i,
  input  logic [31:0] snoop_addr_i,
  output logic        snoop_ready_o,
  output logic [31:0] reservation_addr_o,
  output logic [31:0] reservation_data_o,
  output logic        reservation_valid_o
`ifdef LRSC_STATS_EN
  ,
  output logic [31:0] sc_success_cnt_o,
  output logic [31:0] sc_fail_cnt_o,
  output logic [31:0] snoop_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RESERVED = 2'd1,
    S_SC_BUSY  = 2'd2
  } state_e;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [31:0] NO_RES_ADDR = 32'h0000_0001;

  // Granule index of an address: low GRANULE_LOG2 bits do not take part in matches.
  function automatic logic [31:0] granule(input logic [31:0] a);
    return a >> GRANULE_LOG2;
  endfunction

  state_e         r_state;
  logic [31:0]    r_res_addr;
  logic [31:0]    r_res_data;
  logic [TW-1:0]  r_timer;
  logic           r_valid;
  logic [31:0]    r_addr_o;

  // Stall-qualified pipeline events; snoops and traps are never stalled.
  logic w_lr;
  logic w_sc_start;
  logic w_sc_done;
  logic w_store;
  logic w_snoop_acc;
  logic w_snoop_hits_lr;
  logic w_snoop_hits_res;
  logic w_store_hits_res;
  logic w_expire;

  assign w_lr       = lr_commit_i   & ~stall;
  assign w_sc_start = sc_start_i    & ~stall;
  assign w_sc_done  = sc_done_i     & ~stall;
  assign w_store    = local_store_i & ~stall;

  // NOTE: snoop_ready_o is deliberately combinational on sc_start so that no
  // external write can land in the very cycle the SC sequence begins.
  assign snoop_ready_o = (r_state != S_SC_BUSY) && !w_sc_start;
  assign w_snoop_acc   = snoop_valid_i && snoop_ready_o;

  assign w_snoop_hits_lr  = w_snoop_acc && (granule(snoop_addr_i) == granule(lr_addr_i));
  assign w_snoop_hits_res = w_snoop_acc && (granule(snoop_addr_i) == granule(r_res_addr));
  assign w_store_hits_res = w_store && (granule(local_store_addr_i) == granule(r_res_addr));
  assign w_expire         = (TIMEOUT_CYCLES != 0) && (r_timer == TW'(1));

  // Reservation FSM. Outputs are registered alongside the state: they only
  // change when a reservation is captured or dropped, and SC_BUSY inherits
  // whatever validity the reservation had on entry.
  // NOTE: every register here uses non-blocking assignment and the async reset;
  // mixing blocking assignments into this block would create ordering races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_res_addr <= '0;
      r_res_data <= '0;
      r_timer    <= '0;
      r_valid    <= 1'b0;
      r_addr_o   <= NO_RES_ADDR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sc_start) begin
            r_state <= S_SC_BUSY;
          end else if (w_lr && !w_snoop_hits_lr) begin
            r_state    <= S_RESERVED;
            r_res_addr <= lr_addr_i;
            r_res_data <= lr_data_i;
            r_timer    <= TW'(TIMEOUT_CYCLES);
            r_valid    <= 1'b1;
            r_addr_o   <= lr_addr_i;
          end
        end

        S_RESERVED: begin
          if (trap_i) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_addr_o <= NO_RES_ADDR;
          end else if (w_sc_start) begin
            r_state <= S_SC_BUSY;
          end else if (w_lr) begin
            // A matching snoop in the LR cycle may have overwritten the loaded
            // data, so the new reservation is not trusted.
            if (w_snoop_hits_lr) begin
              r_state  <= S_IDLE;
              r_valid  <= 1'b0;
              r_addr_o <= NO_RES_ADDR;
            end else begin
              r_res_addr <= lr_addr_i;
              r_res_data <= lr_data_i;
              r_timer    <= TW'(TIMEOUT_CYCLES);
              r_addr_o   <= lr_addr_i;
            end
          end else if (w_snoop_hits_res || w_store_hits_res || w_expire) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_addr_o <= NO_RES_ADDR;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_SC_BUSY: begin
          // Traps and LRs cannot occur here: lrsc holds the pipeline.
          if (w_sc_done) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_addr_o <= NO_RES_ADDR;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_valid  <= 1'b0;
          r_addr_o <= NO_RES_ADDR;
        end
      endcase
    end
  end

  assign reservation_valid_o = r_valid;
  assign reservation_addr_o  = r_addr_o;
  assign reservation_data_o  = r_res_data;

`ifdef LRSC_STATS_EN
  logic [31:0] r_sc_success_cnt;
  logic [31:0] r_sc_fail_cnt;
  logic [31:0] r_snoop_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sc_success_cnt  <= '0;
      r_sc_fail_cnt     <= '0;
      r_snoop_stall_cnt <= '0;
    end else begin
      if ((r_state == S_SC_BUSY) && w_sc_done) begin
        if (sc_result_i) begin
          if (r_sc_fail_cnt != '1) r_sc_fail_cnt <= r_sc_fail_cnt + 32'd1;
        end else begin
          if (r_sc_success_cnt != '1) r_sc_success_cnt <= r_sc_success_cnt + 32'd1;
        end
      end
      // Every cycle an external master is held off by the SC sequence.
      if ((r_state == S_SC_BUSY) && snoop_valid_i && (r_snoop_stall_cnt != '1)) begin
        r_snoop_stall_cnt <= r_snoop_stall_cnt + 32'd1;
      end
    end
  end

  assign sc_success_cnt_o  = r_sc_success_cnt;
  assign sc_fail_cnt_o     = r_sc_fail_cnt;
  assign snoop_stall_cnt_o = r_snoop_stall_cnt;
`else
  // The SC result only feeds the statistics counters.
  logic w_unused_sc_result;
  assign w_unused_sc_result = sc_result_i;
`endif

endmodule

// File: tb/tb_lrsc_reservation_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for lrsc_reservation_ctrl: directed scenarios followed by random
// traffic, all compared against a reference model of the reservation rules.
// -----------------------------------------------------------------------------
module tb_lrsc_reservation_ctrl;

  localparam int unsigned T = 4;
  localparam int unsigned G = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        lr_commit_i;
  logic [31:0] lr_addr_i;
  logic [31:0] lr_data_i;
  logic        sc_start_i;
  logic        sc_done_i;
  logic        sc_result_i;
  logic        local_store_i;
  logic [31:0] local_store_addr_i;
  logic        trap_i;
  logic        snoop_valid_i;
  logic [31:0] snoop_addr_i;
  logic        snoop_ready_o;
  logic [31:0] reservation_addr_o;
  logic [31:0] reservation_data_o;
  logic        reservation_valid_o;
`ifdef LRSC_STATS_EN
  logic [31:0] sc_success_cnt_o;
  logic [31:0] sc_fail_cnt_o;
  logic [31:0] snoop_stall_cnt_o;
`endif

  lrsc_reservation_ctrl #(
    .TIMEOUT_CYCLES(T),
    .GRANULE_LOG2  (G)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .stall              (stall),
    .lr_commit_i        (lr_commit_i),
    .lr_addr_i          (lr_addr_i),
    .lr_data_i          (lr_data_i),
    .sc_start_i         (sc_start_i),
    .sc_done_i          (sc_done_i),
    .sc_result_i        (sc_result_i),
    .local_store_i      (local_store_i),
    .local_store_addr_i (local_store_addr_i),
    .trap_i             (trap_i),
    .snoop_valid_i      (snoop_valid_i),
    .snoop_addr_i       (snoop_addr_i),
    .snoop_ready_o      (snoop_ready_o),
    .reservation_addr_o (reservation_addr_o),
    .reservation_data_o (reservation_data_o),
    .reservation_valid_o(reservation_valid_o)
`ifdef LRSC_STATS_EN
    ,
    .sc_success_cnt_o   (sc_success_cnt_o),
    .sc_fail_cnt_o      (sc_fail_cnt_o),
    .snoop_stall_cnt_o  (snoop_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a reservation flag with its address/data and the cycle
  // number of the LR that set it, plus an "SC in flight" flag that remembers
  // whether a reservation existed when the SC began.
  // ---------------------------------------------------------------------------
  bit          m_res;
  bit          m_busy;
  bit          m_busy_res;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  int          m_cyc;
  int          m_lr_cyc;
  int          m_succ;
  int          m_failc;
  int          m_stalls;

  function automatic logic [31:0] gran(input logic [31:0] a);
    return a >> G;
  endfunction

  function automatic bit exp_ready();
    return !m_busy && !(sc_start_i && !stall);
  endfunction

  function automatic bit exp_valid();
    return m_res || (m_busy && m_busy_res);
  endfunction

  function automatic logic [31:0] exp_addr();
    return exp_valid() ? m_addr : 32'h0000_0001;
  endfunction

  task automatic model_reset();
    m_res      = 1'b0;
    m_busy     = 1'b0;
    m_busy_res = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    m_succ     = 0;
    m_failc    = 0;
    m_stalls   = 0;
  endtask

  task automatic model_step();
    bit lr, scs, scd, st, acc;
    lr  = lr_commit_i && !stall;
    scs = sc_start_i && !stall;
    scd = sc_done_i && !stall;
    st  = local_store_i && !stall;
    acc = snoop_valid_i && exp_ready();
    m_cyc++;
    if (m_busy && snoop_valid_i) m_stalls++;
    if (m_busy && scd) begin
      if (sc_result_i) m_failc++;
      else             m_succ++;
    end
    if (m_busy) begin
      if (scd) begin
        m_busy     = 1'b0;
        m_busy_res = 1'b0;
      end
    end else if (m_res && trap_i) begin
      m_res = 1'b0;
    end else if (scs) begin
      m_busy     = 1'b1;
      m_busy_res = m_res;
      m_res      = 1'b0;
    end else if (lr) begin
      if (acc && gran(snoop_addr_i) == gran(lr_addr_i)) begin
        m_res = 1'b0;
      end else begin
        m_res    = 1'b1;
        m_addr   = lr_addr_i;
        m_data   = lr_data_i;
        m_lr_cyc = m_cyc;
      end
    end else if (m_res) begin
      if ((acc && gran(snoop_addr_i) == gran(m_addr)) ||
          (st && gran(local_store_addr_i) == gran(m_addr)) ||
          (T != 0 && (m_cyc - m_lr_cyc) == int'(T)))
        m_res = 1'b0;
    end
  endtask

  task automatic idle();
    stall              = 1'b0;
    lr_commit_i        = 1'b0;
    lr_addr_i          = '0;
    lr_data_i          = '0;
    sc_start_i         = 1'b0;
    sc_done_i          = 1'b0;
    sc_result_i        = 1'b0;
    local_store_i      = 1'b0;
    local_store_addr_i = '0;
    trap_i             = 1'b0;
    snoop_valid_i      = 1'b0;
    snoop_addr_i       = '0;
  endtask

  // One clock: check the combinational ready mid-cycle, advance the model on
  // the edge, then check the registered outputs just after it.
  task automatic cycle();
    @(negedge clk);
    check("snoop_ready", {31'b0, snoop_ready_o}, {31'b0, exp_ready()});
    @(posedge clk);
    model_step();
    #1;
    check("res_valid", {31'b0, reservation_valid_o}, {31'b0, exp_valid()});
    check("res_addr", reservation_addr_o, exp_addr());
    check("res_data", reservation_data_o, m_data);
  endtask

  task automatic do_lr(input logic [31:0] a, input logic [31:0] d);
    idle();
    lr_commit_i = 1'b1;
    lr_addr_i   = a;
    lr_data_i   = d;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] base;
    base = 32'h0000_1000 * $urandom_range(1, 3);
    return base + 32'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    model_reset();
    m_cyc    = 0;
    m_lr_cyc = 0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, snoop_ready_o}, 32'd1);
    check("rst_valid", {31'b0, reservation_valid_o}, 32'd0);
    check("rst_addr", reservation_addr_o, 32'h0000_0001);
    check("rst_data", reservation_data_o, 32'h0);
    reset_n = 1'b1;

    // LR then SC: reservation visible to lrsc, external writes held off.
    do_lr(32'h1000, 32'hDEAD_BEEF); cycle();
    check("lr1_valid", {31'b0, reservation_valid_o}, 32'd1);
    check("lr1_addr", reservation_addr_o, 32'h1000);
    check("lr1_data", reservation_data_o, 32'hDEAD_BEEF);
    idle(); sc_start_i = 1'b1; cycle();
    check("sc_start_ready", {31'b0, snoop_ready_o}, 32'd0);
    check("sc_busy_valid", {31'b0, reservation_valid_o}, 32'd1);
    idle(); cycle();
    check("sc_hold_ready", {31'b0, snoop_ready_o}, 32'd0);
    idle(); sc_done_i = 1'b1; cycle();
    check("sc_done_valid", {31'b0, reservation_valid_o}, 32'd0);
    check("sc_done_addr", reservation_addr_o, 32'h0000_0001);
    check("sc_done_ready", {31'b0, snoop_ready_o}, 32'd1);

    // Snoop in a different granule keeps, same granule kills the reservation.
    do_lr(32'h2000, 32'h1234_5678); cycle();
    idle(); snoop_valid_i = 1'b1; snoop_addr_i = 32'h2004; cycle();
    check("snoop_other_granule", {31'b0, reservation_valid_o}, 32'd1);
    idle(); cycle();
    idle(); snoop_valid_i = 1'b1; snoop_addr_i = 32'h2002; cycle();
    check("snoop_kill_valid", {31'b0, reservation_valid_o}, 32'd0);
    check("snoop_kill_addr", reservation_addr_o, 32'h0000_0001);

    // Timeout: valid for T cycles after the LR edge, gone on the next.
    do_lr(32'h5000, 32'h5555_0000); cycle();
    for (int k = 1; k <= int'(T); k++) begin
      idle(); cycle();
      check("timeout", {31'b0, reservation_valid_o}, {31'b0, k < int'(T)});
    end
    // A second LR on cycle 3 reloads the timer.
    do_lr(32'h5000, 32'h5555_0001); cycle();
    idle(); cycle();
    idle(); cycle();
    do_lr(32'h5008, 32'h5555_0002); cycle();
    for (int k = 1; k <= int'(T); k++) begin
      idle(); cycle();
      check("timeout_reload", {31'b0, reservation_valid_o}, {31'b0, k < int'(T)});
    end

    // Snoop held across an SC: stalled through sc_done, no invalidation.
    do_lr(32'h3000, 32'h3333_3333); cycle();
    idle(); sc_start_i = 1'b1; snoop_valid_i = 1'b1; snoop_addr_i = 32'h3000; cycle();
    for (int k = 0; k < 2; k++) begin
      idle(); snoop_valid_i = 1'b1; snoop_addr_i = 32'h3000; cycle();
      check("sc_snoop_ready", {31'b0, snoop_ready_o}, 32'd0);
      check("sc_snoop_valid", {31'b0, reservation_valid_o}, 32'd1);
    end
    idle(); snoop_valid_i = 1'b1; snoop_addr_i = 32'h3000;
    sc_done_i = 1'b1; sc_result_i = 1'b1; cycle();
    check("sc_after_ready", {31'b0, snoop_ready_o}, 32'd1);
    check("sc_after_valid", {31'b0, reservation_valid_o}, 32'd0);

    // LR with a matching snoop in the same cycle never reserves.
    do_lr(32'h4000, 32'h4444_0000); snoop_valid_i = 1'b1; snoop_addr_i = 32'h4001; cycle();
    check("lr_snoop_valid", {31'b0, reservation_valid_o}, 32'd0);
    do_lr(32'h4000, 32'h4444_4444); cycle();
    idle(); trap_i = 1'b1; cycle();
    check("trap_valid", {31'b0, reservation_valid_o}, 32'd0);

    // Asynchronous reset in the middle of an SC.
    do_lr(32'h6000, 32'h6666_6666); cycle();
    idle(); sc_start_i = 1'b1; cycle();
    idle();
    #2 reset_n = 1'b0;
    #1;
    check("arst_ready", {31'b0, snoop_ready_o}, 32'd1);
    check("arst_valid", {31'b0, reservation_valid_o}, 32'd0);
    check("arst_addr", reservation_addr_o, 32'h0000_0001);
    model_reset();
    #2 reset_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      idle();
      stall              = ($urandom_range(0, 99) < 20);
      lr_commit_i        = ($urandom_range(0, 99) < 25);
      lr_addr_i          = pick_addr();
      lr_data_i          = $urandom;
      sc_start_i         = !lr_commit_i && ($urandom_range(0, 99) < 8);
      sc_done_i          = ($urandom_range(0, 99) < (m_busy ? 35 : 5));
      sc_result_i        = 1'($urandom_range(0, 1));
      local_store_i      = ($urandom_range(0, 99) < 15);
      local_store_addr_i = pick_addr();
      trap_i             = ($urandom_range(0, 99) < 6);
      snoop_valid_i      = ($urandom_range(0, 99) < 30);
      snoop_addr_i       = pick_addr();
      cycle();
    end

`ifdef LRSC_STATS_EN
    check("stat_success", sc_success_cnt_o, 32'(m_succ));
    check("stat_fail", sc_fail_cnt_o, 32'(m_failc));
    check("stat_snoop_stall", snoop_stall_cnt_o, 32'(m_stalls));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lrsc_reservation_ctrl.md
Name: lrsc_reservation_ctrl

Overview:
- Owns the single-hart LR/SC reservation.
  - Sets the reservation on LR retirement.
  - Invalidates it on conflicting writes, traps, or timeout.
  - Feeds reservation address/data to the lrsc sequencer.
- Arbitrates the shared data-memory write path against external masters (DMA/debug): while an SC sequence is in flight, it holds off external writes so the compare-and-store stays atomic.
- Sits beside lrsc in the execute/memory stage, between the core LSU and the bus snoop port.

Parameters:
- TIMEOUT_CYCLES, 64: cycles a reservation stays valid after LR; 0 disables expiry.
- GRANULE_LOG2, 2: reservation granule is 2^GRANULE_LOG2 bytes; address matches ignore bits [GRANULE_LOG2-1:0].

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  pipeline stall; qualifies lr_commit_i, sc_start_i, sc_done_i, local_store_i
- lr_commit_i  in  1  LR.W retires this cycle
- lr_addr_i  in  32  LR effective address
- lr_data_i  in  32  value loaded by LR
- sc_start_i  in  1  lrsc sequencer leaves its idle state (SC begins)
- sc_done_i  in  1  lrsc STORE cycle (final SC cycle)
- sc_result_i  in  1  lrsc result: 0 = success, 1 = fail; valid with sc_done_i
- local_store_i  in  1  ordinary store from this hart commits
- local_store_addr_i  in  32  its address
- trap_i  in  1  exception/interrupt/xRET taken
- snoop_valid_i  in  1  external master requests a write
- snoop_addr_i  in  32  external write address
- snoop_ready_o  out  1  external write may proceed this cycle
- reservation_addr_o  out  32  to lrsc reservation_addr_i
- reservation_data_o  out  32  to lrsc reservation_data_i
- reservation_valid_o  out  1  reservation held

Behaviour:
- Events:
  - lr, sc_start, sc_done and local_store are each the named input ANDed with !stall.
  - Snoop accept = snoop_valid_i && snoop_ready_o; it is never gated by stall.
  - match(a) = (a >> GRANULE_LOG2) == (res_addr >> GRANULE_LOG2).
- FSM states: IDLE, RESERVED, SC_BUSY.
- Reset values:
  - State IDLE; res_addr, res_data and timer = 0.
  - reservation_valid_o = 0; snoop_ready_o = 1 (combinational, see below).
- IDLE:
  - lr -> RESERVED; capture lr_addr_i and lr_data_i; load timer = TIMEOUT_CYCLES.
  - sc_start -> SC_BUSY (reservation stays invalid).
- RESERVED, priority highest first:
  1. trap -> IDLE.
  2. sc_start -> SC_BUSY.
  3. lr -> stay RESERVED, recapture address/data, reload timer.
  4. Accepted snoop matching, local_store matching, or timer reaching 1 -> IDLE.
  5. Otherwise the timer decrements by 1 every cycle, regardless of stall. With TIMEOUT_CYCLES = 0 the timer is not used.
- LR and snoop in the same cycle (IDLE or RESERVED): if the snoop address matches lr_addr_i, the reservation is NOT set. The state goes to IDLE, because the LR data may be stale.
- SC_BUSY:
  - snoop_ready_o = 0.
  - trap_i and lr are ignored; the lrsc unit holds the pipeline.
  - sc_done -> IDLE. The reservation is always cleared after an SC, success or fail.
  - Stall freezes state.
- snoop_ready_o = (state != SC_BUSY) && !sc_start. The combinational path is intentional: no external write may land in the cycle the SC sequence begins.
- Outputs:
  - reservation_valid_o = (state == RESERVED) || (state == SC_BUSY with a reservation captured at entry).
  - When not valid, reservation_addr_o = 32'h0000_0001. This is misaligned, so it never equals an aligned SC address, forcing SC fail.
  - reservation_data_o holds its last value.
  - All outputs except snoop_ready_o are registered.
- Reset mid-SC_BUSY: asynchronous return to IDLE, snoop_ready_o = 1 immediately.
- Snoops arriving while state is IDLE are accepted with no other effect.

Optional Feature:
- Macro LRSC_STATS_EN.
- When defined, adds outputs sc_success_cnt_o[31:0] and sc_fail_cnt_o[31:0], both reset to 0.
  - On sc_done, the counter selected by sc_result_i increments, saturating at 32'hFFFF_FFFF.
  - In SC_BUSY, every cycle with snoop_valid_i = 1 increments snoop_stall_cnt_o[31:0], which also saturates.
- When undefined, these ports and their logic do not exist.

Test Plan:
- LR to 0x1000 with data 0xDEAD_BEEF, then SC start.
  - reservation_addr_o = 0x1000, reservation_data_o = 0xDEADBEEF, valid = 1.
  - snoop_ready_o = 0 until sc_done, then state IDLE, valid = 0.
- LR to 0x2000, then 3 cycles later an accepted snoop write to 0x2002 (GRANULE_LOG2 = 2).
  - Next cycle valid = 0 and reservation_addr_o = 0x0000_0001.
  - A snoop to 0x2004 does not invalidate.
- TIMEOUT_CYCLES = 4: LR, then idle.
  - valid stays 1 for 4 cycles and is 0 from the 5th.
  - A second LR on cycle 3 reloads the timer, keeping valid 1 for 4 more cycles.
- snoop_valid_i held high to 0x3000 across sc_start.
  - snoop_ready_o = 0 from the sc_start cycle through the sc_done cycle, and 1 the cycle after.
  - No invalidation occurs during SC_BUSY.
- LR to 0x4000 with a matching snoop in the same cycle: valid stays 0. Trap in RESERVED: valid = 0 next cycle. Async reset asserted in SC_BUSY: snoop_ready_o = 1 and valid = 0 immediately.
- LRSC_STATS_EN defined: 3 SCs with results 0, 1, 0 give success = 2, fail = 1. A counter preloaded near max saturates at 0xFFFF_FFFF.
